// File: rtl/fifo_demo_pkg.sv
// Widths and grant encoding shared by the FIFO writer, the FIFO itself and the LED-side reader.
package fifo_demo_pkg;
    localparam int DATA_W = 6;
    localparam int CNT_W  = 14;

    localparam logic GRANT_SAMPLER = 1'b0;
    localparam logic GRANT_EXT     = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grants, last winner registered.
// Zero latency; inhibit (FIFO full) or reset suppresses every grant in the same cycle.
module rr_arb2
    import fifo_demo_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inhibit,
    input  logic req_sampler,
    input  logic req_ext,
    output logic gnt_sampler,
    output logic gnt_ext,
    output logic last_grant
);

    always_comb begin
        gnt_sampler = 1'b0;
        gnt_ext     = 1'b0;
        if (rst_n && !inhibit) begin
            // On contention the requester that did not win last time goes first.
            if (req_ext && (!req_sampler || last_grant == GRANT_SAMPLER))
                gnt_ext = 1'b1;
            else if (req_sampler)
                gnt_sampler = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_grant <= GRANT_EXT;
        else if (gnt_sampler || gnt_ext)
            last_grant <= gnt_ext ? GRANT_EXT : GRANT_SAMPLER;
    end

endmodule

// File: rtl/fifo_wr_sched.sv
// Sample counter plus external requester sharing one FIFO write port.
// A sample is written one cycle after its tick; fifo_full blocks writes combinationally and overflow samples are counted.
module fifo_wr_sched
    import fifo_demo_pkg::*;
#(
    parameter int DATA_W    = fifo_demo_pkg::DATA_W,
    parameter int CNT_W     = fifo_demo_pkg::CNT_W,
    parameter int TICK_BITS = 8,
    parameter int DROP_W    = 8
) (
    input  logic              clk_19_3,
    input  logic              reset_button,
    input  logic              enable,
    input  logic              ext_valid,
    input  logic [DATA_W-1:0] ext_data,
    output logic              ext_ready,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              sample_pending,
    output logic              last_grant,
    output logic [DROP_W-1:0] drop_count
);

    logic [CNT_W-1:0]  counter;
    logic [DATA_W-1:0] pending_data;
    logic              tick;
    logic              gnt_sampler;
    logic              gnt_ext;

    assign tick = enable && (counter[TICK_BITS-1:0] == '0);

    rr_arb2 u_arb (
        .clk         (clk_19_3),
        .rst_n       (reset_button),
        .inhibit     (fifo_full),
        .req_sampler (sample_pending),
        .req_ext     (ext_valid),
        .gnt_sampler (gnt_sampler),
        .gnt_ext     (gnt_ext),
        .last_grant  (last_grant)
    );

    assign fifo_wr_en   = gnt_sampler || gnt_ext;
    assign fifo_wr_data = gnt_ext ? ext_data : pending_data;
    assign ext_ready    = gnt_ext;

    always_ff @(posedge clk_19_3) begin
        if (!reset_button) begin
            counter        <= '0;
            sample_pending <= 1'b0;
            pending_data   <= '0;
            drop_count     <= '0;
        end else begin
            if (enable)
                counter <= counter + CNT_W'(1);

            // A same-cycle grant frees the holding register, so a tick then reloads without a drop.
            if (tick) begin
                if (!sample_pending || gnt_sampler) begin
                    sample_pending <= 1'b1;
                    pending_data   <= counter[CNT_W-1 -: DATA_W];
                end else if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_W'(1);
                end
            end else if (gnt_sampler) begin
                sample_pending <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fifo_wr_sched.md
# fifo_wr_sched

Write-side scheduler for the clock-domain FIFO, in the clk_19_3 (fast) domain. It keeps a free-running sample counter and periodically captures its upper bits as a sample. It arbitrates round-robin between that internal sampler and one external valid/ready requester for the single FIFO write port, and never writes while the FIFO reports full. Samples that cannot be queued are counted rather than silently lost.

## Interface
Parameters:
- DATA_W, 6, FIFO word width; sample = counter[CNT_W-1:CNT_W-DATA_W]
- CNT_W, 14, sample counter width
- TICK_BITS, 8, sample tick when counter[TICK_BITS-1:0] == 0
- DROP_W, 8, drop counter width (saturating)

Ports:
- clk_19_3  in  1  sole clock
- reset_button  in  1  synchronous, active-low reset
- enable  in  1  counter run/tick enable
- ext_valid  in  1  external requester has data
- ext_data  in  DATA_W  external word, stable while ext_valid && !ext_ready
- ext_ready  out  1  external word accepted this cycle
- fifo_full  in  1  FIFO write side full
- fifo_wr_en  out  1  write strobe
- fifo_wr_data  out  DATA_W  write word
- sample_pending  out  1  sample holding register occupied
- last_grant  out  1  0 = sampler, 1 = external; last winner
- drop_count  out  DROP_W  samples lost, saturating

## Operation
- Reset (reset_button low at an edge): counter=0, pending=0, pending data=0, last_grant=1, drop_count=0. ext_ready=0 and fifo_wr_en=0 while reset_button is low.
- Counter: +1 per cycle when enable; holds otherwise. Wraps from 2^CNT_W-1 to 0.
- tick = enable && counter[TICK_BITS-1:0]==0, evaluated on the current counter value. The first enabled cycle after reset ticks with sample 0.
- On tick:
  - Pending empty, or pending granted this cycle: load pending with the sample.
  - Otherwise: pending keeps its old value and drop_count += 1, saturating at 2^DROP_W-1.
- Arbitration: candidates are pending (sampler) and ext_valid. No grant while fifo_full.
  - One candidate: it wins.
  - Both: the one != last_grant wins.
  - last_grant updates only on a grant.
- Grant effects:
  - fifo_wr_en=1; fifo_wr_data = winner's data.
  - Sampler win clears pending unless reloaded by a same-cycle tick.
  - External win: ext_ready=1.
- enable low does not block draining. A pending sample and external requests are still written.

## Timing
- fifo_wr_en, fifo_wr_data and ext_ready are combinational from current state, ext_valid and fifo_full. No registered write path, so fifo_full is honoured in the same cycle.
- ext_ready may depend on ext_valid. ext_valid must not depend on ext_ready.
- Sample latency: tick at edge N loads pending. With the FIFO not full and the sampler winning, it is written in cycle N+1.
- Fairness: under continuous contention the winner alternates every write. No requester waits more than one grant.
- Simultaneous tick and pending grant: old sample written, new sample loaded, no drop.
- Tick while fifo_full with pending occupied: drop.
- Reset mid-operation discards pending data. Nothing is written on the reset edge.

## Structure
- Shared package fifo_demo_pkg holds:
  - DATA_W and CNT_W defaults, shared with the FIFO and LED-side reader.
  - Grant encoding constants GRANT_SAMPLER=1'b0 and GRANT_EXT=1'b1.
- Sub-module rr_arb2: two-request round-robin arbiter with a global inhibit (fifo_full) and a last-grant register. The top level holds the counter, pending register, drop counter and data mux.

## Test plan
- Reset, enable=1, ext_valid=0, fifo_full=0 -> fifo_wr_en pulses with data 0x00 one cycle after counter 0 and data 0x01 one cycle after counter 256. No other writes occur; drop_count=0.
- ext_valid=1 constant with ext_data=0x2A, sampler ticking -> ext_ready=1 every cycle except the single cycle after each tick, when the sample is written. last_grant alternates at those points.
- fifo_full=1 across ticks at counters 256 and 512, ext_valid=0 -> pending holds 0x01 and drop_count=1. Release full -> exactly one write of 0x01, then pending=0.
- Run enabled for 16384 cycles -> the tick at 0x3F00 writes 0x3F. The counter wraps, and the tick at 0 writes 0x00.
- With pending=1 and drop_count=3, drive reset_button low for one cycle -> next edge: counter=0, pending=0, drop_count=0, last_grant=1. No fifo_wr_en during reset.
- fifo_full=1 for 300 ticks -> drop_count saturates at 255 and never wraps.
